pll_cfg_seq: RTL
================

// Module: pll_cfg_seq
// PURPOSE
//  Runtime reconfiguration sequencer for an N-output PLL, driving the Avalon-MM management port of a PLL reconfig core.
//  Takes one request carrying M/N/K and per-output C counter words, writes the registers in a fixed order, then starts and polls.
//  Qualifies the PLL lock afterwards and reports done or a lock-timeout error.
//  Sits beside the PLL wrapper. Video and audio clock switching use it instead of fixed-frequency PLL instances.
// PARAMETERS
//  NUM_CLK      3        number of C counters written per request (1..18)
//  FRAC_EN      0        1 = write K (fractional) register; 0 = skip the K state
//  LOCK_STABLE  1024     consecutive synced-lock cycles required before locked=1 (>=2)
//  LOCK_TIMEOUT 1048576  cycles allowed in LOCKWAIT before err (> LOCK_STABLE)
// PORTS
//  refclk           in   1           management clock; all logic on rising edge
//  rst              in   1           synchronous, active-high reset
//  cfg_req          in   1           1-cycle request; sampled only in IDLE
//  cfg_m            in   18          M counter word {bypass,odd,hi[7:0],lo[7:0]}
//  cfg_n            in   18          N counter word, same format
//  cfg_k            in   32          fractional K; ignored when FRAC_EN=0
//  cfg_c            in   18*NUM_CLK  C counter words; C[i] at bits [18*i+17 : 18*i]
//  busy             out  1           high from accepted request until DONE or ERR state
//  done             out  1           1-cycle pulse: reconfig complete and lock qualified
//  err              out  1           1-cycle pulse: LOCK_TIMEOUT expired
//  locked           out  1           qualified lock, valid in every state
//  pll_locked       in   1           raw PLL lock, asynchronous
//  mgmt_address     out  6           reconfig register address
//  mgmt_read        out  1           read strobe
//  mgmt_write       out  1           write strobe
//  mgmt_writedata   out  32          write data
//  mgmt_readdata    in   32          read data
//  mgmt_waitrequest in   1           stall; strobe, address and data held while high
// BEHAVIOUR
//  Reset values: busy=0, done=0, err=0, locked=0, mgmt_read=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0.
//  Reset also clears the state to IDLE and clears all counters and latched cfg.
//  Reset mid-transfer drops the strobe at that edge; the reconfig core must be reset alongside.
//  IDLE: when cfg_req=1, latch all cfg_* words, set busy=1, go to MODE. cfg_req while busy is ignored (no queueing).
//  Bus rule: each state asserts exactly one strobe. It advances on the first edge where strobe=1 and waitrequest=0.
//  The strobe deasserts for exactly 1 cycle between transfers.
//  Write sequence:
//   MODE  addr 0x00 data 1
//   WR_M  0x04 data {14'0,m}
//   WR_N  0x03 data {14'0,n}
//   WR_K  0x07 data k (only if FRAC_EN)
//   WR_C  0x05 data {9'0,idx[4:0],c[idx]}, repeated for idx=0..NUM_CLK-1
//   START 0x02 data 0
//  POLL: read 0x01; on accept, readdata[0]=1 goes to LOCKWAIT, else re-read after the 1-cycle gap. There is no poll limit.
//  LOCKWAIT: the timeout counter starts at 0.
//   Entry to DONE requires locked=1 observed after at least one pll_locked=0 sample, or after LOCK_STABLE fresh cycles.
//   The stable counter restarts on entry.
//   Timeout counter reaching LOCK_TIMEOUT-1 goes to ERR.
//  DONE: done=1 for 1 cycle, busy=0, go to IDLE. ERR: err=1 for 1 cycle, busy=0, go to IDLE.
//  Lock qualifier: 2-flop synchronizer on pll_locked.
//   The stable counter saturates at LOCK_STABLE-1; locked=1 when saturated and sync=1.
//   Any sync=0 clears counter and locked on the next edge, so loss reaches locked within 3 cycles.
//  Counter widths are $clog2 of their limits. idx is a 5-bit wrap-free counter bounded by NUM_CLK.
//  Simultaneous lock loss and timeout in the same cycle: err takes priority.
// STRUCTURE
//  pll_cfg_pkg: register address localparams (MODE, STATUS, START, N, M, C, K) and the state enum:
//   IDLE, MODE, WR_M, WR_N, WR_K, WR_C, START, POLL, LOCKWAIT, DONE, ERR.
//  Sub-module pll_lock_qual: synchronizer plus stable counter; params LOCK_STABLE; ports refclk, rst, pll_locked, locked.
//  Top: FSM, latched cfg registers, idx counter, timeout counter.
// TESTING
//  1 NUM_CLK=3, FRAC_EN=0, no waitrequest, req m=0x00404, n=0x20000, c={0x00202,0x00101,0x00505}
//    -> writes in order 0x00=1, 0x04, 0x03, 0x05 x3 with idx 0,1,2, then 0x02; no 0x07 write.
//  2 waitrequest held high 5 cycles on each transfer
//    -> address, data and strobe stable throughout; no duplicated or skipped register.
//  3 status reads 0,0,1; pll_locked drops, then rises and holds 1024 cycles
//    -> done pulse exactly 1 cycle; busy falls the same edge; locked=1.
//  4 LOCK_TIMEOUT=2000 with pll_locked stuck at 0 -> err pulse 2000 cycles after LOCKWAIT entry; done never asserted.
//  5 cfg_req pulsed during WR_C, and rst asserted mid-POLL
//    -> second request ignored; on reset all outputs return to reset values next edge; a new request restarts at MODE.
//  6 In IDLE with locked=1, pll_locked drops for 1 cycle -> locked=0 within 3 cycles; requalifies after 1024 cycles.

Source files
------------

// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map,
// sequencer states and data-word packing helpers.
package pll_cfg_pkg;

    // Reconfig core register addresses
    localparam logic [5:0] ADDR_MODE   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h01;
    localparam logic [5:0] ADDR_START  = 6'h02;
    localparam logic [5:0] ADDR_N      = 6'h03;
    localparam logic [5:0] ADDR_M      = 6'h04;
    localparam logic [5:0] ADDR_C      = 6'h05;
    localparam logic [5:0] ADDR_K      = 6'h07;

    typedef enum logic [3:0] {
        IDLE, MODE, WR_M, WR_N, WR_K, WR_C, START, POLL, LOCKWAIT, DONE, ERR
    } state_t;

    // M/N counter words go out zero-extended
    function automatic logic [31:0] cnt_word(input logic [17:0] w);
        return {14'b0, w};
    endfunction

    // C counter words carry their counter select above the counter settings
    function automatic logic [31:0] c_word(input logic [4:0] idx, input logic [17:0] c);
        return {9'b0, idx, c};
    endfunction

endpackage

// File: rtl/pll_cfg_seq_if.sv
// Avalon-MM management port between the sequencer and the PLL reconfig core.
interface pll_cfg_seq_if;
    logic [5:0]  mgmt_address;
    logic        mgmt_read;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_address, mgmt_read, mgmt_write, mgmt_writedata,
        input  mgmt_readdata, mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address, mgmt_read, mgmt_write, mgmt_writedata,
        output mgmt_readdata, mgmt_waitrequest
    );
endinterface

// File: rtl/pll_lock_qual.sv
// Lock qualifier: synchronizes the raw PLL lock and only reports lock after
// LOCK_STABLE consecutive synchronized-high cycles. Any low sample drops it.
module pll_lock_qual #(
    parameter int LOCK_STABLE = 1024
) (
    input  logic refclk,
    input  logic rst,
    input  logic pll_locked,
    output logic locked
);
    localparam int CW = $clog2(LOCK_STABLE);
    localparam logic [CW-1:0] SAT = CW'(LOCK_STABLE - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer for the asynchronous raw lock
    always_ff @(posedge refclk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pll_locked;
            s2 <= s1;
        end
    end

    // Saturating stable counter; lock asserts only once saturated
    always_ff @(posedge refclk) begin
        if (rst || !s2) begin
            cnt    <= '0;
            locked <= 1'b0;
        end else begin
            if (cnt != SAT)
                cnt <= cnt + 1'b1;
            locked <= (cnt == SAT);
        end
    end

endmodule

// File: rtl/pll_cfg_seq.sv
// PLL runtime reconfiguration sequencer: latches one request, writes the
// reconfig registers in fixed order, starts the core, polls for completion,
// then waits for a freshly qualified lock or times out.
module pll_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter int NUM_CLK      = 3,
    parameter int FRAC_EN      = 0,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 1048576
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    cfg_req,
    input  logic [17:0]             cfg_m,
    input  logic [17:0]             cfg_n,
    input  logic [31:0]             cfg_k,
    input  logic [18*NUM_CLK-1:0]   cfg_c,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    locked,
    input  logic                    pll_locked,
    pll_cfg_seq_if.master           mgmt
);
    localparam int TW = $clog2(LOCK_TIMEOUT);

    state_t                   state, state_d;
    logic                     gap, gap_d;
    logic [4:0]               idx, idx_d;
    logic [TW-1:0]            tmo;
    logic                     seen_low;
    logic [17:0]              m_q, n_q;
    logic [31:0]              k_q;
    logic [NUM_CLK-1:0][17:0] c_q;
    logic [17:0]              c_sel;
    logic [5:0]               addr_c;
    logic [31:0]              wdata_c;
    logic                     wr_c, rd_c, acc;
    logic                     last_c, tmo_hit, lock_ok;

    pll_lock_qual #(.LOCK_STABLE(LOCK_STABLE)) u_lock (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .locked     (locked)
    );

    // Select the C word for the current counter index
    always_comb begin
        c_sel = '0;
        for (int i = 0; i < NUM_CLK; i++)
            if (idx == 5'(i)) c_sel = c_q[i];
    end

    // Bus decode: each bus state owns one strobe, suppressed for the gap cycle
    always_comb begin
        addr_c  = '0;
        wdata_c = '0;
        wr_c    = 1'b0;
        rd_c    = 1'b0;
        case (state)
            MODE:  begin addr_c = ADDR_MODE;   wdata_c = 32'd1;          wr_c = !gap; end
            WR_M:  begin addr_c = ADDR_M;      wdata_c = cnt_word(m_q);  wr_c = !gap; end
            WR_N:  begin addr_c = ADDR_N;      wdata_c = cnt_word(n_q);  wr_c = !gap; end
            WR_K:  begin addr_c = ADDR_K;      wdata_c = k_q;            wr_c = !gap; end
            WR_C:  begin addr_c = ADDR_C;      wdata_c = c_word(idx, c_sel); wr_c = !gap; end
            START: begin addr_c = ADDR_START;  wdata_c = 32'd0;          wr_c = !gap; end
            POLL:  begin addr_c = ADDR_STATUS;                           rd_c = !gap; end
            default: ;
        endcase
    end

    assign acc     = (wr_c || rd_c) && !mgmt.mgmt_waitrequest;
    assign last_c  = (idx == 5'(NUM_CLK - 1));
    assign tmo_hit = (tmo == TW'(LOCK_TIMEOUT - 1));
    // Lock must be fresh: either it dropped and requalified inside LOCKWAIT,
    // or it has held for a full qualification window since entry.
    assign lock_ok = locked && (seen_low || tmo >= TW'(LOCK_STABLE));

    // Next-state logic; an accepted transfer always forces one idle gap cycle
    always_comb begin
        state_d = state;
        idx_d   = idx;
        gap_d   = acc;
        case (state)
            IDLE:     if (cfg_req) state_d = MODE;
            MODE:     if (acc) state_d = WR_M;
            WR_M:     if (acc) state_d = WR_N;
            WR_N:     if (acc) state_d = (FRAC_EN != 0) ? WR_K : WR_C;
            WR_K:     if (acc) state_d = WR_C;
            WR_C: begin
                if (acc) begin
                    if (last_c) begin
                        idx_d   = '0;
                        state_d = START;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            START:    if (acc) state_d = POLL;
            POLL:     if (acc && mgmt.mgmt_readdata[0]) state_d = LOCKWAIT;
            LOCKWAIT: begin
                if (tmo_hit)      state_d = ERR;
                else if (lock_ok) state_d = DONE;
            end
            DONE:     state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= IDLE;
            gap   <= 1'b0;
            idx   <= '0;
        end else begin
            state <= state_d;
            gap   <= gap_d;
            idx   <= idx_d;
        end
    end

    // Request latch, timeout counter and lock-freshness tracking
    always_ff @(posedge refclk) begin
        if (rst) begin
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            c_q      <= '0;
            tmo      <= '0;
            seen_low <= 1'b0;
        end else begin
            if (state == IDLE && cfg_req) begin
                m_q <= cfg_m;
                n_q <= cfg_n;
                k_q <= cfg_k;
                c_q <= cfg_c;
            end
            if (state == LOCKWAIT) begin
                tmo <= tmo + 1'b1;
                if (!locked) seen_low <= 1'b1;
            end else begin
                tmo      <= '0;
                seen_low <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE) && (state != DONE) && (state != ERR);
    assign done = (state == DONE);
    assign err  = (state == ERR);

    assign mgmt.mgmt_address   = addr_c;
    assign mgmt.mgmt_writedata = wdata_c;
    assign mgmt.mgmt_write     = wr_c;
    assign mgmt.mgmt_read      = rd_c;

endmodule
